// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus carry flop,
// LSB first, WIDTH cycles per result with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, a_nxt;
    logic [WIDTH-1:0] b_reg, b_nxt;
    logic [WIDTH-1:0] res, res_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             c, c_nxt;
    logic             carry_nxt;
    logic             done_nxt;
    logic             s;
    logic             last;

    assign s    = a_reg[0] ^ b_reg[0] ^ c;
    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            res   <= res_nxt;
            cnt   <= cnt_nxt;
            c     <= c_nxt;
            sum   <= sum_nxt;
            carry <= carry_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        res_nxt   = res;
        cnt_nxt   = cnt;
        c_nxt     = c;
        sum_nxt   = sum;
        carry_nxt = carry;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    c_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                c_nxt   = (a_reg[0] & b_reg[0]) | (a_reg[0] & c) | (b_reg[0] & c);
                res_nxt = {s, res[WIDTH-1:1]};
                a_nxt   = a_reg >> 1;
                b_nxt   = b_reg >> 1;
                cnt_nxt = cnt + 1'b1;
                // Final bit: publish result; start is ignored here by design
                if (last) begin
                    sum_nxt   = res_nxt;
                    carry_nxt = c_nxt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder, checked against
// plain a+b arithmetic and the WIDTH-cycle latency rule.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [3:0] sum;
    logic       carry;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [7:0] sum8;
    logic       carry8;

    int total = 0;
    int bad   = 0;
    logic [4:0] last4;
    logic [8:0] last8;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=4 addition; optionally pokes start while busy.
    task automatic op4(input logic [3:0] x, input logic [3:0] y,
                       input bit inject);
        logic [4:0] exp;
        exp   = 5'(x) + 5'(y);
        a     = x;
        b     = y;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (inject && k == 0) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end else begin
                start = 1'b0;
                a     = 4'($urandom);
                b     = 4'($urandom);
            end
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("hold_run", {carry, sum}, last4);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_end", done, 1);
        chk("busy_end", busy, 0);
        chk("result", {carry, sum}, exp);
        last4 = exp;
    endtask

    task automatic idle4(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("done_idle", done, 0);
            chk("busy_idle", busy, 0);
            chk("hold_idle", {carry, sum}, last4);
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] exp;
        exp    = 9'(x) + 9'(y);
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            chk("busy8_run", busy8, 1);
            chk("done8_run", done8, 0);
            chk("hold8_run", {carry8, sum8}, last8);
        end
        @(posedge clk); #1;
        chk("done8_end", done8, 1);
        chk("busy8_end", busy8, 0);
        chk("result8", {carry8, sum8}, exp);
        last8 = exp;
        @(posedge clk); #1;
        chk("done8_drop", done8, 0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        last4  = '0;
        last8  = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", {carry, sum}, 0);
        chk("rst_busy8", busy8, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        op4(4'd8, 4'd3, 0);
        idle4(1);
        op4(4'd15, 4'd1, 0);
        op4(4'd5, 4'd7, 0);
        op4(4'd0, 4'd0, 0);
        idle4(2);

        op4(4'd9, 4'd7, 1);
        idle4(3);

        for (int i = 0; i < 256; i++)
            op4(4'(i >> 4), 4'(i), 0);
        idle4(1);

        op4(4'd11, 4'd13, 0);
        a     = 4'd12;
        b     = 4'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_res", {carry, sum}, 0);
        last4 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle4(6);
        op4(4'd2, 4'd2, 0);

        for (int i = 0; i < 60; i++) begin
            op4(4'($urandom), 4'($urandom), bit'($urandom_range(0, 1)));
            idle4(int'($urandom_range(0, 2)));
        end

        op8(8'd200, 8'd100);
        for (int i = 0; i < 10; i++)
            op8(8'($urandom), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder, the additive counterpart to the team's combinational subtractor. It accepts two WIDTH-bit operands on a start pulse and adds them one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents the sum and carry-out with a one-cycle done pulse. It sits in the arithmetic library as a low-area alternative where a WIDTH-bit ripple adder is too large and latency is tolerable.

## Interface
- WIDTH, default 4: operand and sum width in bits, minimum 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only while busy=0.
- a  input  WIDTH  first operand, unsigned; captured on an accepted start.
- b  input  WIDTH  second operand, unsigned; captured on an accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse when sum and carry hold a new result.
- sum  output  WIDTH  low WIDTH bits of a+b; holds its value until the next result.
- carry  output  1  bit WIDTH of a+b (carry-out); holds its value with sum.

## Operation
- The block has two states, IDLE and RUN. Reset puts it in IDLE.
- Reset values: busy=0, done=0, sum=0, carry=0. Internal operand registers, shift register, carry flip-flop and bit counter are all cleared.
- IDLE, with start=1 at a rising edge:
  - capture a and b into operand shift registers;
  - clear the carry flip-flop and set the bit counter to 0;
  - go to RUN with busy=1.
- IDLE, with start=0: hold all state.
- RUN, on each edge:
  - s = a_reg[0] ^ b_reg[0] ^ c;
  - c <= majority(a_reg[0], b_reg[0], c);
  - shift s into the MSB of the result shift register, which shifts right;
  - shift the operand registers right;
  - increment the counter.
- RUN, on the edge that processes bit WIDTH-1:
  - load sum with the completed result and carry with the final carry;
  - assert done for exactly one cycle, drop busy, and return to IDLE.
- Arithmetic: {carry, sum} equals the (WIDTH+1)-bit value a+b for all operand pairs. There is no overflow beyond carry.
- sum and carry do not change during RUN. They change only on the completing edge or on reset.
- start while busy=1 is ignored. The operands in flight are unaffected.
- a and b are don't-care except on the edge that accepts start.
- start=1 on the cycle done=1 (busy=0) is accepted. This gives back-to-back operation with no idle gap.
- Reset asserted mid-operation aborts the addition: no done pulse, and sum and carry return to 0.

## Timing
- If start is accepted at edge N:
  - busy=1 after edges N through N+WIDTH-1;
  - at edge N+WIDTH: busy=0, done=1, and sum and carry are valid.
- Latency from the accepting edge to a valid result is WIDTH cycles. Throughput is one result per WIDTH cycles.
- done is high for one cycle only. It falls at edge N+WIDTH+1 unless a new operation completes there, which cannot happen for WIDTH≥2.
- Reset acts immediately and asynchronously on all registers. The first edge after reset deasserts may accept start.

## Test plan
- a=8, b=3, start pulse -> done exactly 4 cycles later, sum=11, carry=0. busy is high for 4 cycles.
- a=15, b=1 -> sum=0, carry=1. Then a=5, b=7 -> sum=12, carry=0. Then a=0, b=0 -> sum=0, carry=0. sum and carry hold the prior result throughout each RUN.
- Exhaustive: all 256 (a,b) pairs at WIDTH=4, back-to-back with start on each done cycle -> {carry,sum}==a+b every time, one result per 4 cycles.
- Start with a=9, b=7. One cycle later, pulse start with a=1, b=1 -> second start ignored. Result is sum=0, carry=1, and only one done pulse occurs.
- Start a=12, b=6, assert rst after 2 cycles -> busy, done, sum and carry all go to 0 immediately, and no done pulse follows. A later start with a=2, b=2 gives sum=4.
- WIDTH=8 instance: a=200, b=100 -> done after 8 cycles, sum=44, carry=1.
